// File: rtl/sfr_seq_pkg.sv
// Shared definitions for the SFR script sequencer: FSM state codes,
// script entry layout helpers and the default SFR target indices.
package sfr_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_FETCH    = 3'd1;
  localparam state_t ST_GAP      = 3'd2;
  localparam state_t ST_WAIT_RDY = 3'd3;
  localparam state_t ST_ISSUE    = 3'd4;

  // Default strobe target indices for the uart0 / measurement-core SFRs.
  localparam int TGT_SCON = 0;
  localparam int TGT_SMD0 = 1;
  localparam int TGT_SMD1 = 2;
  localparam int TGT_SPLS = 3;
  localparam int TGT_SCCL = 4;
  localparam int TGT_SBUF = 5;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Entry layout, MSB to LSB: {last, wait, tgt, data, gap}.
  function automatic int entry_w(input int tgt_iw, input int data_w, input int gap_w);
    return 2 + tgt_iw + data_w + gap_w;
  endfunction

  function automatic int gap_lsb();
    return 0;
  endfunction

  function automatic int data_lsb(input int gap_w);
    return gap_w;
  endfunction

  function automatic int tgt_lsb(input int data_w, input int gap_w);
    return gap_w + data_w;
  endfunction

  function automatic int wait_bit(input int tgt_iw, input int data_w, input int gap_w);
    return gap_w + data_w + tgt_iw;
  endfunction

  function automatic int last_bit(input int tgt_iw, input int data_w, input int gap_w);
    return gap_w + data_w + tgt_iw + 1;
  endfunction

endpackage

// File: rtl/sfr_seq_ram.sv
// Script RAM: DEPTH x ENTRY_W, synchronous write port, combinational read.
// Contents are not reset; they are undefined until written.
module sfr_seq_ram #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int ENTRY_W = 21
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Single write port, one cycle per entry.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sfr_script_seq.sv
// SFR write script sequencer. Replays script RAM entries in order, spacing
// them in frame ticks, optionally waiting for a per-target ready, and issues
// a one-hot single-cycle write strobe with a shared write-data bus.
// Build option: define SFR_SEQ_LOOP_EN to make a last entry (or the end of
// the RAM) wrap to entry 0 and keep replaying until abort.
module sfr_script_seq
  import sfr_seq_pkg::*;
#(
  parameter int FRAME_W = 16,
  parameter int DEPTH   = 64,
  parameter int TGT_N   = 8,
  parameter int DATA_W  = 8,
  parameter int GAP_W   = 8,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int TGT_IW  = idx_w(TGT_N),
  parameter int ENTRY_W = entry_w(TGT_IW, DATA_W, GAP_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_data,
  input  logic               start,
  input  logic               abort,
  input  logic [TGT_N-1:0]   tgt_ready,
  output logic [DATA_W-1:0]  sfr_wdata,
  output logic [TGT_N-1:0]   wctrl,
  output logic               busy,
  output logic               done,
  output logic               err
);

`ifdef SFR_SEQ_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  localparam int GAP_LSB  = gap_lsb();
  localparam int DATA_LSB = data_lsb(GAP_W);
  localparam int TGT_LSB  = tgt_lsb(DATA_W, GAP_W);
  localparam int WAIT_BIT = wait_bit(TGT_IW, DATA_W, GAP_W);
  localparam int LAST_BIT = last_bit(TGT_IW, DATA_W, GAP_W);
  // Latched entry drops the gap field; the gap goes straight into gap_cnt.
  localparam int ENT_W    = ENTRY_W - GAP_W;

  // A target index is valid only below TGT_N.
  function automatic logic tgt_ok(input logic [TGT_IW-1:0] t);
    return ({1'b0, t} < (TGT_IW+1)'(TGT_N));
  endfunction

  // Ready gate for an entry; an invalid target never stalls so it can be skipped.
  function automatic logic rdy_pass(input logic [TGT_IW-1:0] t, input logic [TGT_N-1:0] r);
    logic p;
    p = 1'b1;
    for (int i = 0; i < TGT_N; i++) begin
      if (t == TGT_IW'(i)) p = r[i];
    end
    return p;
  endfunction

  // State reached once an entry's gap is exhausted.
  function automatic state_t after_gap(input logic w, input logic rdy);
    return (w && !rdy) ? ST_WAIT_RDY : ST_ISSUE;
  endfunction

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [FRAME_W-1:0]  frame_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [DATA_W-1:0]   wdata_q;
  logic                done_q;
  logic                err_q;
  logic [ENTRY_W-1:0]  ram_rd;
  logic [ENT_W-1:0]    ent_p0;

  logic                frame_tick;
  logic                start_acc;
  logic                ram_we;
  logic [GAP_W-1:0]    rd_gap;
  logic                rd_wait;
  logic [TGT_IW-1:0]   rd_tgt;
  logic [DATA_W-1:0]   e_data;
  logic [TGT_IW-1:0]   e_tgt;
  logic                e_wait;
  logic                e_last;
  logic                e_tgt_ok;
  logic                gap_last;
  logic                end_of_script;
  logic                issue_go;
  logic                strobe_go;

  assign frame_tick = &frame_cnt;
  assign start_acc  = (state == ST_IDLE) && start && !abort;
  assign ram_we     = cfg_we && (state == ST_IDLE);

  sfr_seq_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .ENTRY_W(ENTRY_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(cfg_addr),
    .wdata(cfg_data),
    .raddr(ptr),
    .rdata(ram_rd)
  );

  // Fetch stage: fields seen directly on the RAM read port
  assign rd_gap  = ram_rd[GAP_LSB +: GAP_W];
  assign rd_wait = ram_rd[WAIT_BIT];
  assign rd_tgt  = ram_rd[TGT_LSB +: TGT_IW];

  // Issue stage: fields of the latched entry (offsets shifted by GAP_W)
  assign e_data   = ent_p0[DATA_LSB - GAP_W +: DATA_W];
  assign e_tgt    = ent_p0[TGT_LSB - GAP_W +: TGT_IW];
  assign e_wait   = ent_p0[WAIT_BIT - GAP_W];
  assign e_last   = ent_p0[LAST_BIT - GAP_W];
  assign e_tgt_ok = tgt_ok(e_tgt);

  assign gap_last      = (gap_cnt <= GAP_W'(1));
  assign end_of_script = e_last || (ptr == ADDR_W'(DEPTH - 1));
  assign issue_go      = (state == ST_ISSUE) && !abort;
  assign strobe_go     = issue_go && e_tgt_ok;

  // Next-state selection; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (rd_gap != '0) state_nxt = ST_GAP;
        else              state_nxt = after_gap(rd_wait, rdy_pass(rd_tgt, tgt_ready));
      end
      ST_GAP: begin
        if (frame_tick && gap_last)
          state_nxt = after_gap(e_wait, rdy_pass(e_tgt, tgt_ready));
      end
      ST_WAIT_RDY: begin
        if (rdy_pass(e_tgt, tgt_ready)) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (end_of_script) state_nxt = LOOP_EN ? ST_FETCH : ST_IDLE;
        else               state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Control registers: FSM, script pointer, frame/gap counters, status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      frame_cnt <= '0;
      gap_cnt   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= start_acc ? '0 : frame_cnt + 1'b1;
      done_q    <= 1'b0;
      if (start_acc) begin
        ptr   <= '0;
        err_q <= 1'b0;
      end
      if (state == ST_FETCH)
        gap_cnt <= rd_gap;
      else if ((state == ST_GAP) && frame_tick)
        gap_cnt <= gap_cnt - 1'b1;
      if (issue_go) begin
        if (e_tgt_ok) wdata_q <= e_data;
        else          err_q   <= 1'b1;
        if (end_of_script) begin
          done_q <= 1'b1;
          ptr    <= '0;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
    end
  end

  // Fetch -> issue boundary: entry register captured during FETCH
  always_ff @(posedge clk) begin
    if (state == ST_FETCH) ent_p0 <= ram_rd[ENTRY_W-1:GAP_W];
  end

  // One-hot strobe decode, only while a valid entry issues.
  always_comb begin
    wctrl = '0;
    for (int i = 0; i < TGT_N; i++) begin
      wctrl[i] = strobe_go && (e_tgt == TGT_IW'(i));
    end
  end

  // New data appears with its strobe and is then held until the next issue.
  assign sfr_wdata = strobe_go ? e_data : wdata_q;
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sfr_script_seq.sv
// Scoreboard bench for sfr_script_seq: directed scripts push expected
// strobe/done events with their cycle numbers; a monitor pops and compares.
module tb_sfr_script_seq;

  localparam int FRAME_W = 4;
  localparam int DEPTH   = 8;
  localparam int TGT_N   = 6;
  localparam int DATA_W  = 8;
  localparam int GAP_W   = 8;
  localparam int ADDR_W  = 3;
  localparam int ENTRY_W = 21;

  localparam int SCON = 0, SMD0 = 1, SMD1 = 2, SBUF = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [ENTRY_W-1:0] cfg_data;
  logic               start;
  logic               abort;
  logic [TGT_N-1:0]   tgt_ready;
  logic [DATA_W-1:0]  sfr_wdata;
  logic [TGT_N-1:0]   wctrl;
  logic               busy;
  logic               done;
  logic               err;

  sfr_script_seq #(
    .FRAME_W(FRAME_W),
    .DEPTH  (DEPTH),
    .TGT_N  (TGT_N),
    .DATA_W (DATA_W),
    .GAP_W  (GAP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .start    (start),
    .abort    (abort),
    .tgt_ready(tgt_ready),
    .sfr_wdata(sfr_wdata),
    .wctrl    (wctrl),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit               is_done;
    int               at;
    logic [TGT_N-1:0] strb;
    logic [DATA_W-1:0] data;
  } ev_t;

  ev_t sbq[$];
  ev_t mon_e;
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic exp_strobe(input int at, input int tgt, input int data);
    ev_t e;
    e.is_done = 1'b0;
    e.at      = at;
    e.strb    = TGT_N'(1) << tgt;
    e.data    = DATA_W'(data);
    sbq.push_back(e);
  endtask

  task automatic exp_done(input int at);
    ev_t e;
    e.is_done = 1'b1;
    e.at      = at;
    e.strb    = '0;
    e.data    = '0;
    sbq.push_back(e);
  endtask

  function automatic logic [ENTRY_W-1:0] ent(input bit last, input bit w, input int tgt,
                                             input int data, input int gap);
    return {last, w, 3'(tgt), 8'(data), 8'(gap)};
  endfunction

  task automatic wr(input int a, input logic [ENTRY_W-1:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = ADDR_W'(a);
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic go(output int s);
    @(negedge clk);
    start = 1'b1;
    s     = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: samples just after the falling edge, well away from the active edge.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      while (sbq.size() > 0 && sbq[0].at < cyc) begin
        chk(sbq[0].is_done ? "missing_done_cycle" : "missing_strobe_cycle", cyc, sbq[0].at);
        void'(sbq.pop_front());
      end
      if (wctrl != '0) begin
        chk("wctrl_onehot", 32'($onehot(wctrl)), 1);
        if (sbq.size() == 0) begin
          chk("unexpected_strobe", wctrl, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("event_kind_strobe", mon_e.is_done, 0);
          chk("strobe_cycle", cyc, mon_e.at);
          chk("wctrl", wctrl, mon_e.strb);
          chk("sfr_wdata", sfr_wdata, mon_e.data);
        end
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("event_kind_done", mon_e.is_done, 1);
          chk("done_cycle", cyc, mon_e.at);
          chk("busy_with_done", busy, `ifdef SFR_SEQ_LOOP_EN 1 `else 0 `endif);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int r;
    rst       = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    start     = 1'b0;
    abort     = 1'b0;
    tgt_ready = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wctrl", wctrl, 0);
    chk("rst_sfr_wdata", sfr_wdata, 0);
    rst = 1'b1;

    // Three back-to-back entries; a stray start mid-run must be ignored.
    wr(0, ent(0, 0, SCON, 'h82, 0));
    wr(1, ent(0, 0, SMD1, 'h09, 0));
    wr(2, ent(1, 0, SBUF, 'hFB, 0));
    go(s);
    exp_strobe(s + 2, SCON, 'h82);
    exp_strobe(s + 4, SMD1, 'h09);
    exp_strobe(s + 6, SBUF, 'hFB);
    exp_done(s + 7);
    to_cyc(s + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to_cyc(s + 6);
    chk("busy_running", busy, 1);
    to_cyc(s + 7);
    chk("busy_fall_with_done", busy, 0);
    to_cyc(s + 9);
    chk("wdata_held_idle", sfr_wdata, 'hFB);

    // Gap of 3 frames (16-cycle frames): strobe 48 cycles after FETCH.
    // A write attempted mid-replay must not alter the script.
    wr(0, ent(1, 0, SMD0, 'h3C, 3));
    go(s);
    exp_strobe(s + 49, SMD0, 'h3C);
    exp_done(s + 50);
    to_cyc(s + 10);
    wr(0, ent(1, 0, SCON, 'h99, 0));
    to_cyc(s + 48);
    chk("busy_in_gap", busy, 1);
    to_cyc(s + 52);
    go(s);
    exp_strobe(s + 49, SMD0, 'h3C);
    exp_done(s + 50);
    to_cyc(s + 52);

    // Wait for SBUF ready: held 100 cycles, strobe one cycle after ready.
    wr(0, ent(1, 1, SBUF, 'h5A, 0));
    tgt_ready = 6'h1F;
    go(s);
    to_cyc(s + 2);
    repeat (100) @(negedge clk);
    chk("busy_waiting", busy, 1);
    r = cyc;
    exp_strobe(r + 1, SBUF, 'h5A);
    exp_done(r + 2);
    tgt_ready = 6'h3F;
    to_cyc(r + 4);
    tgt_ready = '0;

    // Invalid target 7: no strobe, sticky err, next entry still issues.
    wr(0, ent(0, 0, 7, 'h11, 0));
    wr(1, ent(1, 0, SCON, 'h22, 0));
    go(s);
    exp_strobe(s + 4, SCON, 'h22);
    exp_done(s + 5);
    to_cyc(s + 3);
    chk("err_set_bad_tgt", err, 1);
    chk("wdata_not_taken_bad_tgt", sfr_wdata, 'h5A);
    to_cyc(s + 8);
    chk("err_sticky", err, 1);
    go(s);
    chk("err_cleared_by_start", err, 0);
    exp_strobe(s + 4, SCON, 'h22);
    exp_done(s + 5);
    to_cyc(s + 8);

    // Abort during GAP.
    wr(0, ent(0, 0, SCON, 'h33, 2));
    wr(1, ent(1, 0, SMD0, 'h44, 0));
    go(s);
    to_cyc(s + 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_after_gap_abort", busy, 0);
    to_cyc(s + 40);

    // Abort in the ISSUE cycle suppresses that strobe.
    wr(0, ent(0, 0, SCON, 'h55, 0));
    go(s);
    to_cyc(s + 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_after_issue_abort", busy, 0);
    to_cyc(s + 10);
    chk("wdata_kept_after_abort", sfr_wdata, 'h22);

    // Abort together with start in IDLE: stays idle.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", busy, 0);

    // Replay after abort restarts from entry 0.
    go(s);
    exp_strobe(s + 2, SCON, 'h55);
    exp_strobe(s + 4, SMD0, 'h44);
    exp_done(s + 5);
    to_cyc(s + 8);

    // Full RAM without a last flag.
    for (int i = 0; i < DEPTH; i++) wr(i, ent(0, 0, i % 6, 'hA0 + i, 0));
    go(s);
`ifdef SFR_SEQ_LOOP_EN
    for (int i = 0; i < 2 * DEPTH; i++) begin
      exp_strobe(s + 2 + 2 * i, (i % DEPTH) % 6, 'hA0 + (i % DEPTH));
      if (i % DEPTH == DEPTH - 1) exp_done(s + 3 + 2 * i);
    end
    to_cyc(s + 34);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("loop_abort_idle", busy, 0);
    to_cyc(s + 40);

    // Two-entry looping script.
    wr(0, ent(0, 0, SCON, 'h01, 0));
    wr(1, ent(1, 0, SMD0, 'h02, 0));
    go(s);
    exp_strobe(s + 2, SCON, 'h01);
    exp_strobe(s + 4, SMD0, 'h02);
    exp_done(s + 5);
    exp_strobe(s + 6, SCON, 'h01);
    exp_strobe(s + 8, SMD0, 'h02);
    exp_done(s + 9);
    to_cyc(s + 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("loop2_abort_idle", busy, 0);
    to_cyc(s + 16);
`else
    for (int i = 0; i < DEPTH; i++) exp_strobe(s + 2 + 2 * i, i % 6, 'hA0 + i);
    exp_done(s + 2 * DEPTH + 1);
    to_cyc(s + 2 * DEPTH + 3);
    chk("depth_end_idle", busy, 0);
`endif

    for (int k = 0; k < 200 && sbq.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfr_script_seq.md
Name: sfr_script_seq

Overview:
Synthesizable, parametrised successor to the frame-slot SFR write scripting used to configure uart0 and the measurement core. A loadable script RAM holds entries of the form {last, wait, target, data, gap}. On start, the block replays the entries in order, spaced in frame ticks, and issues one-hot single-cycle write strobes plus a shared write-data bus. It sits between the host/boot logic and the SFR write ports of uart0 and mic_fpga_top.

Parameters:
FRAME_W, 16, frame length is 2**FRAME_W clk cycles
DEPTH, 64, number of script entries (power of 2)
TGT_N, 8, number of write-strobe targets
DATA_W, 8, SFR data width
GAP_W, 8, per-entry gap field width in frames
ADDR_W, $clog2(DEPTH), script address width (derived)
TGT_IW, $clog2(TGT_N), target index width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
cfg_we  in  1  script RAM write enable
cfg_addr  in  ADDR_W  script RAM write address
cfg_data  in  ENTRY_W  entry {last[1], wait[1], tgt[TGT_IW], data[DATA_W], gap[GAP_W]}; ENTRY_W = 2+TGT_IW+DATA_W+GAP_W
start  in  1  begin replay from entry 0
abort  in  1  stop replay
tgt_ready  in  TGT_N  per-target ready (e.g. UART TI); consulted only when the entry's wait bit is set
sfr_wdata  out  DATA_W  write data, held stable from the ISSUE cycle until the next ISSUE
wctrl  out  TGT_N  one-hot write strobe, one cycle wide
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse after the last entry is issued
err  out  1  sticky: bad target index seen; cleared by start

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. On reset: state=IDLE, ptr=0, frame counter=0, sfr_wdata=0, wctrl=0, busy=0, done=0, err=0. Script RAM is not reset (contents are undefined until written).
- Frame counter: free-running FRAME_W bits; frame_tick fires when the counter is all ones. It clears to 0 on an accepted start.
- States: IDLE, FETCH, GAP, WAIT_RDY, ISSUE.
- IDLE: start=1 -> FETCH; ptr=0; err cleared.
- FETCH (1 cycle): latch RAM[ptr] into the entry register. Next state:
  - GAP if gap!=0;
  - else WAIT_RDY if wait=1 and tgt_ready[tgt]=0;
  - else ISSUE.
- GAP: decrement the gap count on each frame_tick. When the count reaches 0, go to WAIT_RDY or ISSUE by the same rule as FETCH.
- WAIT_RDY: hold until tgt_ready[tgt]=1, then ISSUE on the next cycle. There is no timeout.
- ISSUE (1 cycle): wctrl[tgt]=1 and sfr_wdata=data in the same cycle. If tgt>=TGT_N: no strobe, err set, entry skipped.
- After ISSUE:
  - if last=1 or ptr==DEPTH-1 -> IDLE, done pulses for 1 cycle in the following cycle;
  - else ptr+1 -> FETCH.
- Latency: an entry with gap=0 and wait=0 strobes 2 cycles after its FETCH begins, so back-to-back entries issue every 2 cycles.
- abort: has priority over every transition. The next state is IDLE, with no strobe and no done pulse. Abort in the same cycle as ISSUE suppresses that strobe. Abort together with start in IDLE: abort wins and the block stays in IDLE.
- start while busy: ignored.
- cfg_we while busy: ignored, so the script is immutable during replay. cfg_we in IDLE writes in 1 cycle.
- wctrl is never multi-hot, and is never asserted outside ISSUE.

Optional Feature:
SFR_SEQ_LOOP_EN
- Defined: a `last` entry returns to ptr=0 and FETCH instead of IDLE; done pulses on each wrap; replay continues until abort.
- Undefined: single-shot replay as described in Behaviour.

Decomposition:
- Shared package sfr_seq_pkg:
  - state enum;
  - entry field offsets/widths;
  - ENTRY_W function;
  - default target index constants (SCON=0, SMD0=1, SMD1=2, SPLS=3, SCCL=4, SBUF=5).
- One natural sub-module: sfr_seq_ram (DEPTH x ENTRY_W, write port plus combinational read).

Test Plan:
- Load 3 entries {tgt=SCON, data=0x82, gap=0}, {SMD1, 0x09, 0}, {SBUF, 0xFB, 0, last}; pulse start -> wctrl one-hot strobes at start+2, +4, +6 with matching data; done pulses 1 cycle after the third strobe; busy falls at the same time.
- FRAME_W=4, entry gap=3 -> strobe occurs after exactly 3 frame_ticks (48±1 cycles after FETCH); verify against the cycle count.
- Entry wait=1, tgt=SBUF, tgt_ready[5]=0 for 100 cycles then 1 -> no strobe during the 100 cycles; strobe 1 cycle after ready rises.
- Entry tgt=7 with TGT_N=6 -> no wctrl, err=1; next entry still issues; a new start clears err.
- abort asserted during GAP and again during the ISSUE cycle -> no strobe, no done, IDLE next cycle; a subsequent start replays from entry 0.
- SFR_SEQ_LOOP_EN defined, 2-entry script -> strobe pattern repeats, done pulses per wrap; ptr reaches DEPTH-1 without last -> wraps (loop) or ends with done (no loop).
